// File: rtl/control.sv
// control -- main control unit of the MIPS-subset processor.
//
// Decodes the instruction opcode/funct fields into datapath strobes and a
// 4-bit ALU operation code. A two-state run FSM (IDLE/RUN) gates every
// output: in IDLE, or while Reset is held low, every output reads 0.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge active
//   Reset     in   asynchronous active-low reset
//   opcode    in   instruction bits [31:26]
//   funct     in   instruction bits [5:0], meaningful only for R-type
//   Run       in   run enable, sampled on the rising edge
//   pc_write  out  PC write enable (high whenever the FSM is in RUN)
//   Regwrite  out  register-file write enable
//   Aluscr    out  ALU B operand select (1 = immediate)
//   Pcsrc     out  branch sense (1 = bne, 0 = beq)
//   branch    out  conditional branch
//   MemWrite  out  data-memory write
//   MemRead   out  data-memory read
//   regRead   out  instruction reads the register file
//   MemtoReg  out  write-back select (1 = memory data)
//   ALUOP     out  ALU operation code
//   jump      out  unconditional jump

module control (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       Run,
   output logic       pc_write,
   output logic       Regwrite,
   output logic       Aluscr,
   output logic       Pcsrc,
   output logic       branch,
   output logic       MemWrite,
   output logic       MemRead,
   output logic       regRead,
   output logic       MemtoReg,
   output logic [3:0] ALUOP,
   output logic       jump
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // ALU operation codes
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0011;
   localparam logic [3:0] ALU_NOR  = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SUBU = 4'b1001;
   localparam logic [3:0] ALU_ADDU = 4'b1011;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t state;

   logic       dec_regwrite;
   logic       dec_aluscr;
   logic       dec_pcsrc;
   logic       dec_branch;
   logic       dec_memwrite;
   logic       dec_memread;
   logic       dec_regread;
   logic       dec_memtoreg;
   logic       dec_jump;
   logic [3:0] dec_aluop;
   logic       running;

   // Run FSM. Both transitions reduce to following Run on each edge, but the
   // case form keeps the two states explicit. Reset forces IDLE without a clock.
   always_ff @(posedge CLOCK_50 or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (Run)  state <= RUN;
            RUN:     if (!Run) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Instruction decode, purely combinational so the strobes track opcode/funct
   // with no latency. Anything not recognised falls through as a NOP.
   always_comb begin
      dec_regwrite = 1'b0;
      dec_aluscr   = 1'b0;
      dec_pcsrc    = 1'b0;
      dec_branch   = 1'b0;
      dec_memwrite = 1'b0;
      dec_memread  = 1'b0;
      dec_regread  = 1'b0;
      dec_memtoreg = 1'b0;
      dec_jump     = 1'b0;
      dec_aluop    = ALU_AND;
      case (opcode)
         OP_RTYPE: begin
            dec_regwrite = 1'b1;
            dec_regread  = 1'b1;
            case (funct)
               6'b100000: dec_aluop = ALU_ADD;
               6'b100010: dec_aluop = ALU_SUB;
               6'b100100: dec_aluop = ALU_AND;
               6'b100101: dec_aluop = ALU_OR;
               6'b100111: dec_aluop = ALU_NOR;
               6'b100110: dec_aluop = ALU_XOR;
               6'b101010: dec_aluop = ALU_SLT;
               6'b000000: dec_aluop = ALU_SLL;
               6'b000010: dec_aluop = ALU_SRL;
               6'b100011: dec_aluop = ALU_SUBU;
               6'b100001: dec_aluop = ALU_ADDU;
               default: begin
                  // Unknown funct (including jr) is a NOP: undo the R-type strobes.
                  dec_regwrite = 1'b0;
                  dec_regread  = 1'b0;
               end
            endcase
         end
         OP_ADDI: begin
            dec_regwrite = 1'b1;
            dec_regread  = 1'b1;
            dec_aluscr   = 1'b1;
            dec_aluop    = ALU_ADD;
         end
         OP_ANDI: begin
            dec_regwrite = 1'b1;
            dec_regread  = 1'b1;
            dec_aluscr   = 1'b1;
            dec_aluop    = ALU_AND;
         end
         OP_ORI: begin
            dec_regwrite = 1'b1;
            dec_regread  = 1'b1;
            dec_aluscr   = 1'b1;
            dec_aluop    = ALU_OR;
         end
         OP_LW: begin
            dec_regwrite = 1'b1;
            dec_regread  = 1'b1;
            dec_aluscr   = 1'b1;
            dec_memread  = 1'b1;
            dec_memtoreg = 1'b1;
            dec_aluop    = ALU_ADD;
         end
         OP_SW: begin
            dec_regread  = 1'b1;
            dec_aluscr   = 1'b1;
            dec_memwrite = 1'b1;
            dec_aluop    = ALU_ADD;
         end
         OP_BEQ: begin
            dec_branch   = 1'b1;
            dec_regread  = 1'b1;
            dec_aluop    = ALU_SUB;
         end
         OP_BNE: begin
            dec_branch   = 1'b1;
            dec_regread  = 1'b1;
            dec_pcsrc    = 1'b1;
            dec_aluop    = ALU_SUB;
         end
         OP_J: begin
            dec_jump     = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Output gating by the registered state. Since the reset clears the state
   // asynchronously, every output drops to 0 as soon as Reset goes low.
   assign running  = (state == RUN);
   assign pc_write = running;
   assign Regwrite = running & dec_regwrite;
   assign Aluscr   = running & dec_aluscr;
   assign Pcsrc    = running & dec_pcsrc;
   assign branch   = running & dec_branch;
   assign MemWrite = running & dec_memwrite;
   assign MemRead  = running & dec_memread;
   assign regRead  = running & dec_regread;
   assign MemtoReg = running & dec_memtoreg;
   assign jump     = running & dec_jump;
   assign ALUOP    = running ? dec_aluop : 4'b0000;

endmodule

// File: tb/tb_control.sv
// tb_control -- scoreboard testbench for the control unit.
//
// A stimulus process drives Run/opcode/funct at each falling edge, looks the
// instruction up by mnemonic in a reference table, and pushes the expected
// output word into a queue. A monitor process pops the queue and compares it
// against the DUT a short time later.

module tb_control;

   logic       clk;
   logic       reset_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       run;
   logic       pc_write, regwrite, aluscr, pcsrc, branch;
   logic       memwrite, memread, regread, memtoreg, jump;
   logic [3:0] aluop;

   control dut (
      .CLOCK_50 (clk),
      .Reset    (reset_n),
      .opcode   (opcode),
      .funct    (funct),
      .Run      (run),
      .pc_write (pc_write),
      .Regwrite (regwrite),
      .Aluscr   (aluscr),
      .Pcsrc    (pcsrc),
      .branch   (branch),
      .MemWrite (memwrite),
      .MemRead  (memread),
      .regRead  (regread),
      .MemtoReg (memtoreg),
      .ALUOP    (aluop),
      .jump     (jump)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected word layout:
   // {pc_write, Regwrite, regRead, Aluscr, MemRead, MemtoReg, MemWrite,
   //  branch, Pcsrc, jump, ALUOP[3:0]}
   logic [12:0] behaviour [string];
   string       r_name [logic [5:0]];
   string       i_name [logic [5:0]];

   logic [13:0] exp_q [$];
   string       name_q [$];
   event        check_ev;
   int          checks = 0;
   int          errors = 0;
   bit          model_running = 1'b0;

   function automatic logic [12:0] mk(input bit rw, input bit rr, input bit as,
                                      input bit mr, input bit m2r, input bit mw,
                                      input bit br, input bit pcs, input bit jmp,
                                      input logic [3:0] op);
      return {rw, rr, as, mr, m2r, mw, br, pcs, jmp, op};
   endfunction

   // Reference tables: encoding -> mnemonic -> behaviour
   initial begin
      r_name[6'b100000] = "add";   r_name[6'b100010] = "sub";
      r_name[6'b100100] = "and";   r_name[6'b100101] = "or";
      r_name[6'b100111] = "nor";   r_name[6'b100110] = "xor";
      r_name[6'b101010] = "slt";   r_name[6'b000000] = "sll";
      r_name[6'b000010] = "srl";   r_name[6'b100011] = "subu";
      r_name[6'b100001] = "addu";
      i_name[6'b001000] = "addi";  i_name[6'b001100] = "andi";
      i_name[6'b001101] = "ori";   i_name[6'b100011] = "lw";
      i_name[6'b101011] = "sw";    i_name[6'b000100] = "beq";
      i_name[6'b000101] = "bne";   i_name[6'b000010] = "j";
      behaviour["add"]  = mk(1,1,0,0,0,0,0,0,0,4'd2);
      behaviour["sub"]  = mk(1,1,0,0,0,0,0,0,0,4'd3);
      behaviour["and"]  = mk(1,1,0,0,0,0,0,0,0,4'd0);
      behaviour["or"]   = mk(1,1,0,0,0,0,0,0,0,4'd1);
      behaviour["nor"]  = mk(1,1,0,0,0,0,0,0,0,4'd4);
      behaviour["xor"]  = mk(1,1,0,0,0,0,0,0,0,4'd5);
      behaviour["slt"]  = mk(1,1,0,0,0,0,0,0,0,4'd6);
      behaviour["sll"]  = mk(1,1,0,0,0,0,0,0,0,4'd7);
      behaviour["srl"]  = mk(1,1,0,0,0,0,0,0,0,4'd8);
      behaviour["subu"] = mk(1,1,0,0,0,0,0,0,0,4'd9);
      behaviour["addu"] = mk(1,1,0,0,0,0,0,0,0,4'd11);
      behaviour["addi"] = mk(1,1,1,0,0,0,0,0,0,4'd2);
      behaviour["andi"] = mk(1,1,1,0,0,0,0,0,0,4'd0);
      behaviour["ori"]  = mk(1,1,1,0,0,0,0,0,0,4'd1);
      behaviour["lw"]   = mk(1,1,1,1,1,0,0,0,0,4'd2);
      behaviour["sw"]   = mk(0,1,1,0,0,1,0,0,0,4'd2);
      behaviour["beq"]  = mk(0,1,0,0,0,0,1,0,0,4'd3);
      behaviour["bne"]  = mk(0,1,0,0,0,0,1,1,0,4'd3);
      behaviour["j"]    = mk(0,0,0,0,0,0,0,0,1,4'd0);
      behaviour["nop"]  = 13'd0;
   end

   function automatic string mnemonic(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'b000000)
         return r_name.exists(fn) ? r_name[fn] : "nop";
      return i_name.exists(op) ? i_name[op] : "nop";
   endfunction

   // Drive one instruction at the falling edge, queue its expected response,
   // then advance the model's run state at the following rising edge.
   task automatic applyStimulus(input bit r, input logic [5:0] op, input logic [5:0] fn);
      string nm;
      @(negedge clk);
      run    = r;
      opcode = op;
      funct  = fn;
      nm = mnemonic(op, fn);
      exp_q.push_back(model_running ? {1'b1, behaviour[nm]} : 14'd0);
      name_q.push_back(model_running ? nm : {nm, "/idle"});
      -> check_ev;
      @(posedge clk);
      #1;
      model_running = reset_n && r;
   endtask

   // Pull reset low between edges; the outputs must clear with no clock.
   task automatic resetMidCycle();
      #2;
      reset_n = 1'b0;
      model_running = 1'b0;
      exp_q.push_back(14'd0);
      name_q.push_back("async_reset");
      -> check_ev;
   endtask

   task automatic checkOutput(input logic [13:0] expv, input string nm);
      logic [13:0] act;
      act = {pc_write, regwrite, regread, aluscr, memread, memtoreg, memwrite,
             branch, pcsrc, jump, aluop};
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", nm, act, expv, $time);
      end
   endtask

   // Monitor: pops one expectation per presented cycle and compares.
   initial begin
      forever begin
         @(check_ev);
         #1;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_underflow: got empty queue expected entry");
         end else begin
            checkOutput(exp_q.pop_front(), name_q.pop_front());
         end
      end
   end

   logic [5:0] r_functs [11] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b100111, 6'b100110, 6'b101010, 6'b000000,
                                 6'b000010, 6'b100011, 6'b100001};
   logic [5:0] i_ops [8] = '{6'b100011, 6'b101011, 6'b001100, 6'b001101,
                             6'b001000, 6'b000100, 6'b000101, 6'b000010};

   initial begin
      reset_n = 1'b0;
      run     = 1'b1;
      opcode  = 6'b000000;
      funct   = 6'b100000;

      // Held in reset with Run=1 and an add on the bus
      repeat (5) applyStimulus(1'b1, 6'b000000, 6'b100000);

      // Release; first cycle is still IDLE, then RUN
      reset_n = 1'b1;
      applyStimulus(1'b1, 6'b000000, 6'b100000);
      foreach (r_functs[i]) applyStimulus(1'b1, 6'b000000, r_functs[i]);
      foreach (i_ops[i]) applyStimulus(1'b1, i_ops[i], 6'b000000);
      applyStimulus(1'b1, 6'b000011, 6'b000000);
      applyStimulus(1'b1, 6'b000000, 6'b001001);

      // Drop Run: this cycle still RUN, next cycle outputs clear
      applyStimulus(1'b0, 6'b100011, 6'b000000);
      applyStimulus(1'b0, 6'b100011, 6'b000000);
      applyStimulus(1'b1, 6'b000000, 6'b100000);
      applyStimulus(1'b1, 6'b101011, 6'b000000);

      // Asynchronous reset between edges while running
      resetMidCycle();
      applyStimulus(1'b1, 6'b000000, 6'b100000);
      reset_n = 1'b1;

      // Randomised phase
      for (int n = 0; n < 400; n++) begin
         logic [5:0] op, fn;
         bit r;
         r = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 2))
            0: begin op = 6'b000000; fn = r_functs[$urandom_range(0, 10)]; end
            1: begin op = i_ops[$urandom_range(0, 7)]; fn = 6'($urandom); end
            default: begin op = 6'($urandom); fn = 6'($urandom); end
         endcase
         applyStimulus(r, op, fn);
         if ($urandom_range(0, 40) == 0) begin
            resetMidCycle();
            applyStimulus(r, op, fn);
            reset_n = 1'b1;
         end
      end

      // Drain the scoreboard, bounded
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
